soc_system_control_source: RTL and testbench
============================================

Name: soc_system_control_source

Overview:
- Upstream producer of the 32-bit word sampled by the HPS-readable control PIO (`in_port`).
- Synchronises and debounces the board switches and push-buttons.
- Counts key-press events so software can detect new presses by polling alone. The PIO read has no side effects and no acknowledge path exists.
- Drives a fully registered, glitch-free `ctrl_word` straight into the PIO input.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable-input cycles required before a debounced bit changes (10 ms at 50 MHz). Must be >= 2.
- CNT_W, 20, width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock (50 MHz)
- reset_n  input  1  asynchronous, active-low reset
- sw_in  input  10  raw slide switches, active-high, asynchronous to clk
- key_n_in  input  4  raw push-buttons, active-low (0 = pressed), asynchronous to clk
- ctrl_word  output  32  packed status word, connects to control PIO `in_port`

Behaviour:
- Clocking and reset:
  - Single clock domain `clk`.
  - Reset is asynchronous and active-low on `reset_n`; all flops clear immediately when `reset_n` = 0.
- Synchronisation:
  - Each of the 14 raw inputs passes through a 2-flop synchroniser.
  - Keys are inverted after synchronisation, so internal 1 = pressed.
  - Reset values: switch sync flops 0; key sync flops 1 (raw released).
- Debounce, per bit (14 independent instances, shared DEBOUNCE_CYCLES):
  - If the synced bit equals the stable bit, the counter clears to 0.
  - Otherwise the counter increments. When the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, the stable bit takes the synced value and the counter clears.
  - A single mismatching sample followed by a matching one restarts the count, so a glitch shorter than DEBOUNCE_CYCLES never propagates.
  - Reset: stable switches 0, stable keys 0 (released), all counters 0.
- Press events:
  - press[i] is a one-cycle pulse when stable key i goes 0->1. Releases generate no event.
  - Switches never generate events.
  - On any cycle where press != 0:
    - seq (8-bit) increments by exactly 1, even if several keys are pressed in that same cycle.
    - last_press (4-bit) is loaded with the press mask; several keys in one cycle give several bits set.
  - seq wraps 255 -> 0 with no flag.
  - Reset: seq = 0, last_press = 0.
  - A key held through reset release debounces to pressed after DEBOUNCE_CYCLES and produces one press event.
- Output packing (registered; ctrl_word updates on every clk edge from current internal state):
  - [9:0] stable switches
  - [13:10] stable keys (1 = held)
  - [17:14] last_press
  - [25:18] seq
  - [31:26] 0 (reserved, always 0)
- Output reset value: ctrl_word = 32'h0000_0000.
- Latency, from a raw edge held steady:
  - Stable bit changes 2 (sync) + DEBOUNCE_CYCLES cycles after the edge.
  - ctrl_word reflects the change 1 cycle later.
  - seq/last_press update in the same ctrl_word cycle as the key bit.
- Reset mid-debounce: counters and stable bits clear; debounce restarts from scratch after release.
- No combinational path from any input to ctrl_word.

Test Plan (bench uses DEBOUNCE_CYCLES = 4):
1. Reset with all keys released and sw_in = 0 -> ctrl_word = 0 during reset and for all cycles after release.
2. sw_in set 10'h2A5 and held -> ctrl_word[9:0] = 10'h2A5 exactly 7 cycles after the edge (2 sync + 4 debounce + 1 output register); bits [31:10] unchanged.
3. key_n_in[2] low for 3 cycles, then high -> no change in ctrl_word (glitch rejected). Low for 10 cycles -> [12] = 1, [17:14] = 4'b0100, seq = 1. Release -> [12] = 0, seq stays 1, last_press stays 4'b0100.
4. key_n_in[0] and key_n_in[3] fall on the same edge -> one event: seq +1, last_press = 4'b1001, [13:10] = 4'b1001.
5. 256 isolated presses of key 1 from reset -> seq reads 1..255 then 0; [31:26] = 0 throughout.
6. Assert reset_n low midway through a key debounce count, then release with the key still held -> ctrl_word = 0 asynchronously while reset is low. After release: key bit, seq = 1 and last_press = 4'b0010 (key 1 held) all appear together, 7 cycles after reset release.

Source files
------------

// File: rtl/soc_system_control_source.sv
// Board switch/key front end for the HPS control PIO: synchronise, debounce,
// count key presses, and present one fully registered 32-bit status word.
module soc_system_control_source #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  sw_in,
    input  logic [3:0]  key_n_in,
    output logic [31:0] ctrl_word
);

    localparam int unsigned NB = 14;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [9:0]              sw_sync1_q, sw_sync2_q;
    logic [3:0]              key_sync1_q, key_sync2_q;
    logic [NB-1:0]           synced;
    logic [NB-1:0]           stable_q, stable_d;
    logic [NB-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]              press;
    logic [7:0]              seq_q, seq_d;
    logic [3:0]              last_press_q, last_press_d;
    logic [31:0]             ctrl_word_q, ctrl_word_d;

    // Key sync flops reset to 1 so a reset looks like "all released" on the raw side.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_sync1_q  <= '0;
            sw_sync2_q  <= '0;
            key_sync1_q <= '1;
            key_sync2_q <= '1;
        end else begin
            sw_sync1_q  <= sw_in;
            sw_sync2_q  <= sw_sync1_q;
            key_sync1_q <= key_n_in;
            key_sync2_q <= key_sync1_q;
        end
    end

    assign synced = {~key_sync2_q, sw_sync2_q};

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NB; i++) begin
            if (synced[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = synced[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Press detection looks ahead at stable_d so seq/last_press land on the
    // same edge as the key bit and appear together in ctrl_word.
    assign press = stable_d[13:10] & ~stable_q[13:10];

    always_comb begin
        seq_d        = seq_q;
        last_press_d = last_press_q;
        if (press != 4'b0000) begin
            seq_d        = seq_q + 8'd1;
            last_press_d = press;
        end
    end

    // ctrl_word carries no handshake: it is a level that software may sample
    // at any time, so it is always driven from a flop to stay glitch-free.
    assign ctrl_word_d = {6'b000000, seq_q, last_press_q, stable_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q     <= '0;
            cnt_q        <= '0;
            seq_q        <= '0;
            last_press_q <= '0;
            ctrl_word_q  <= '0;
        end else begin
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            seq_q        <= seq_d;
            last_press_q <= last_press_d;
            ctrl_word_q  <= ctrl_word_d;
        end
    end

    assign ctrl_word = ctrl_word_q;

endmodule

// File: tb/tb_soc_system_control_source.sv
// Directed bench for soc_system_control_source with DEBOUNCE_CYCLES = 4: each
// expected ctrl_word change (value and cycle) is queued and matched by a monitor.
module tb_soc_system_control_source;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  sw_in;
    logic [3:0]  key_n_in;
    logic [31:0] ctrl_word;

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] prev_word = 32'h0;
    logic [31:0] mon_v;
    int          mon_c;

    soc_system_control_source #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw_in    (sw_in),
        .key_n_in (key_n_in),
        .ctrl_word(ctrl_word)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] v, input int c);
        exp_q.push_back(v);
        exp_cyc_q.push_back(c);
    endtask

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every change of ctrl_word must match the head of the queue,
    // both in value and in the cycle it appears.
    always @(negedge clk) begin
        if (ctrl_word !== prev_word) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got %h at cycle %0d, no change expected", ctrl_word, cyc);
            end else begin
                mon_v = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                if (ctrl_word !== mon_v || cyc != mon_c) begin
                    errors++;
                    $display("FAIL word_change: got %h at cycle %0d, want %h at cycle %0d",
                             ctrl_word, cyc, mon_v, mon_c);
                end
            end
            prev_word = ctrl_word;
        end else if (exp_q.size() != 0 && cyc > exp_cyc_q[0]) begin
            checks++;
            errors++;
            mon_v = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            $display("FAIL missing_change: got %h at cycle %0d, want %h at cycle %0d",
                     ctrl_word, cyc, mon_v, mon_c);
        end
    end

    initial begin
        reset_n  = 1'b1;
        sw_in    = 10'h000;
        key_n_in = 4'hF;

        // 1: reset with everything released
        #1 reset_n = 1'b0;
        #2 check_now("reset_state", ctrl_word, 32'h0);
        next_cycle(3);
        check_now("reset_hold", ctrl_word, 32'h0);
        reset_n = 1'b1;
        next_cycle(10);
        check_now("idle_after_reset", ctrl_word, 32'h0);

        // 2: switches, 7-cycle latency
        sw_in = 10'h2A5;
        expect_word(32'h0000_02A5, cyc + 7);
        next_cycle(10);

        // 3: 3-cycle glitch rejected, then a real press and release of key 2
        key_n_in[2] = 1'b0;
        next_cycle(3);
        key_n_in[2] = 1'b1;
        next_cycle(10);
        key_n_in[2] = 1'b0;
        expect_word(32'h0005_12A5, cyc + 7);
        next_cycle(10);
        key_n_in[2] = 1'b1;
        expect_word(32'h0005_02A5, cyc + 7);
        next_cycle(10);

        // 4: keys 0 and 3 together give a single event
        key_n_in = 4'b0110;
        expect_word(32'h000A_66A5, cyc + 7);
        next_cycle(10);
        key_n_in = 4'hF;
        expect_word(32'h000A_42A5, cyc + 7);
        next_cycle(10);
        sw_in = 10'h000;
        expect_word(32'h000A_4000, cyc + 7);
        next_cycle(10);

        // Reset before the wrap test; output clears asynchronously
        reset_n = 1'b0;
        expect_word(32'h0, cyc);
        #1 check_now("async_clear", ctrl_word, 32'h0);
        next_cycle(3);
        reset_n = 1'b1;
        next_cycle(10);

        // 5: 256 presses of key 1, seq wraps to 0
        for (int n = 1; n <= 256; n++) begin
            key_n_in[1] = 1'b0;
            expect_word({6'b000000, 8'(n), 4'b0010, 4'b0010, 10'h000}, cyc + 7);
            next_cycle(8);
            key_n_in[1] = 1'b1;
            expect_word({6'b000000, 8'(n), 4'b0010, 4'b0000, 10'h000}, cyc + 7);
            next_cycle(8);
        end

        // 6: reset in the middle of a key-1 debounce, key held through release
        key_n_in[1] = 1'b0;
        next_cycle(4);
        reset_n = 1'b0;
        expect_word(32'h0, cyc);
        #1 check_now("async_clear_mid", ctrl_word, 32'h0);
        next_cycle(3);
        check_now("reset_held_mid", ctrl_word, 32'h0);
        reset_n = 1'b1;
        expect_word(32'h0004_8800, cyc + 7);
        next_cycle(12);
        key_n_in[1] = 1'b1;
        expect_word(32'h0004_8000, cyc + 7);
        next_cycle(10);

        // Every queued change must have been seen
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending changes want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
